// File: rtl/pc_pkg.sv
// Shared types and default sizing for the program-counter / fetch sequencer slice.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } pc_state_t;

  localparam int PC_W       = 12;
  localparam int IMEM_DEPTH = 1024;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC adder (sequential or signed-offset branch) with instruction-memory range check.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int D         = PC_W,
  parameter int MEM_DEPTH = IMEM_DEPTH
) (
  input  logic [D-1:0] prog_ptr,
  input  logic [D-1:0] target,
  input  logic         branch_en,
  output logic [D-1:0] next,
  output logic         oob
);

  // Plain D-bit add: a negative offset in two's complement wraps modulo 2^D.
  always_comb begin
    next = prog_ptr + (branch_en ? target : D'(1));
    oob  = ({1'b0, next} >= (D+1)'(MEM_DEPTH));
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and run/halt/fault sequencer driving the instruction-memory fetch address.
//
//   state  | meaning
//   IDLE   | after reset, waiting for Start; prog_ptr holds
//   RUN    | fetching; PC advances, branches, or stalls each cycle
//   HALTED | halt retired; everything holds until Start
//   FAULT  | next fetch address fell outside instruction memory; waits for Start
module pc_fetch_sequencer
  import pc_pkg::*;
#(
  parameter int D         = PC_W,
  parameter int MEM_DEPTH = IMEM_DEPTH,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [D-1:0]     start_addr,
  input  logic             branch_en,
  input  logic [D-1:0]     target,
  input  logic             stall,
  input  logic             halt,
  output logic [D-1:0]     prog_ptr,
  output logic             running,
  output logic             Done,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  pc_state_t        state_q, state_d;
  logic [D-1:0]     prog_ptr_q, prog_ptr_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic             fault_q, fault_d;

  logic [D-1:0]     next_pc;
  logic             next_oob;
  logic [CNT_W-1:0] count_inc;

  pc_next_calc #(
    .D         (D),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_next_calc (
    .prog_ptr  (prog_ptr_q),
    .target    (target),
    .branch_en (branch_en),
    .next      (next_pc),
    .oob       (next_oob)
  );

  assign count_inc = (&instr_count_q) ? instr_count_q : instr_count_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    prog_ptr_d    = prog_ptr_q;
    instr_count_d = instr_count_q;
    done_d        = 1'b0;

    if (Start) begin
      state_d       = RUN;
      prog_ptr_d    = start_addr;
      instr_count_d = '0;
    end else if (state_q == RUN) begin
      if (halt) begin
        state_d       = HALTED;
        done_d        = 1'b1;
        instr_count_d = count_inc;
      end else if (!stall) begin
        // An out-of-range fetch is never issued: PC keeps the last legal address.
        if (next_oob) begin
          state_d = FAULT;
        end else begin
          prog_ptr_d    = next_pc;
          instr_count_d = count_inc;
        end
      end
    end

    running_d = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      prog_ptr_q    <= '0;
      instr_count_q <= '0;
      done_q        <= 1'b0;
      running_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_ptr_q    <= prog_ptr_d;
      instr_count_q <= instr_count_d;
      done_q        <= done_d;
      running_q     <= running_d;
      fault_q       <= fault_d;
    end
  end

  assign prog_ptr    = prog_ptr_q;
  assign running     = running_q;
  assign Done        = done_q;
  assign fault       = fault_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; a second narrow-counter instance covers saturation.
module tb_pc_fetch_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [11:0] start_addr;
  logic        branch_en;
  logic [11:0] target;
  logic        stall;
  logic        halt;
  logic [11:0] prog_ptr;
  logic        running;
  logic        Done;
  logic        fault;
  logic [15:0] instr_count;

  logic [11:0] s_prog_ptr;
  logic        s_running;
  logic        s_done;
  logic        s_fault;
  logic [3:0]  s_count;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_sequencer #(.D(12), .MEM_DEPTH(1024), .CNT_W(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .start_addr  (start_addr),
    .branch_en   (branch_en),
    .target      (target),
    .stall       (stall),
    .halt        (halt),
    .prog_ptr    (prog_ptr),
    .running     (running),
    .Done        (Done),
    .fault       (fault),
    .instr_count (instr_count)
  );

  pc_fetch_sequencer #(.D(12), .MEM_DEPTH(1024), .CNT_W(4)) dut_sat (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .start_addr  (start_addr),
    .branch_en   (branch_en),
    .target      (target),
    .stall       (stall),
    .halt        (halt),
    .prog_ptr    (s_prog_ptr),
    .running     (s_running),
    .Done        (s_done),
    .fault       (s_fault),
    .instr_count (s_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] addr);
    Start = 1'b1; start_addr = addr;
    step();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (prog_ptr !== 12'h000) begin n_fail++; $display("FAIL reset_ptr got %h exp %h", prog_ptr, 12'h000); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b exp 0", running); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", Done); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b exp 0", fault); end
    n_tests++; if (instr_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h exp 0000", instr_count); end
    Reset = 1'b1;
    step();
    n_tests++; if (prog_ptr !== 12'h000 || running !== 1'b0) begin n_fail++; $display("FAIL idle_hold got ptr=%h run=%b exp ptr=000 run=0", prog_ptr, running); end
  endtask

  task automatic test_start_increment();
    do_start(12'h010);
    n_tests++; if (prog_ptr !== 12'h010) begin n_fail++; $display("FAIL start_ptr got %h exp 010", prog_ptr); end
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got %b exp 1", running); end
    n_tests++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL start_count got %0d exp 0", instr_count); end
    step();
    n_tests++; if (prog_ptr !== 12'h011 || instr_count !== 16'd1) begin n_fail++; $display("FAIL inc1 got ptr=%h cnt=%0d exp ptr=011 cnt=1", prog_ptr, instr_count); end
    step();
    n_tests++; if (prog_ptr !== 12'h012 || instr_count !== 16'd2) begin n_fail++; $display("FAIL inc2 got ptr=%h cnt=%0d exp ptr=012 cnt=2", prog_ptr, instr_count); end
  endtask

  task automatic test_branch();
    do_start(12'h020);
    branch_en = 1'b1; target = 12'hFFB;
    step();
    n_tests++; if (prog_ptr !== 12'h01B || instr_count !== 16'd1) begin n_fail++; $display("FAIL branch_neg got ptr=%h cnt=%0d exp ptr=01b cnt=1", prog_ptr, instr_count); end
    target = 12'h014;
    step();
    n_tests++; if (prog_ptr !== 12'h02F || instr_count !== 16'd2) begin n_fail++; $display("FAIL branch_pos got ptr=%h cnt=%0d exp ptr=02f cnt=2", prog_ptr, instr_count); end
  endtask

  task automatic test_stall();
    stall = 1'b1; branch_en = 1'b1; target = 12'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (prog_ptr !== 12'h02F || instr_count !== 16'd2 || running !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d got ptr=%h cnt=%0d run=%b exp ptr=02f cnt=2 run=1", i, prog_ptr, instr_count, running); end
    end
    stall = 1'b0; branch_en = 1'b0;
    step();
    n_tests++; if (prog_ptr !== 12'h030 || instr_count !== 16'd3) begin n_fail++; $display("FAIL stall_resume got ptr=%h cnt=%0d exp ptr=030 cnt=3", prog_ptr, instr_count); end
  endtask

  task automatic test_halt();
    do_start(12'h040);
    halt = 1'b1; branch_en = 1'b1; target = 12'h005;
    step();
    halt = 1'b0; branch_en = 1'b0;
    n_tests++; if (Done !== 1'b1) begin n_fail++; $display("FAIL halt_done got %b exp 1", Done); end
    n_tests++; if (running !== 1'b0 || prog_ptr !== 12'h040 || instr_count !== 16'd1) begin n_fail++; $display("FAIL halt_state got run=%b ptr=%h cnt=%0d exp run=0 ptr=040 cnt=1", running, prog_ptr, instr_count); end
    step();
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL halt_done_pulse got %b exp 0", Done); end
    step();
    n_tests++; if (prog_ptr !== 12'h040 || running !== 1'b0 || instr_count !== 16'd1 || fault !== 1'b0) begin n_fail++; $display("FAIL halted_hold got ptr=%h run=%b cnt=%0d flt=%b exp ptr=040 run=0 cnt=1 flt=0", prog_ptr, running, instr_count, fault); end
  endtask

  task automatic test_fault();
    do_start(12'h3FE);
    step();
    n_tests++; if (prog_ptr !== 12'h3FF || instr_count !== 16'd1) begin n_fail++; $display("FAIL top_addr got ptr=%h cnt=%0d exp ptr=3ff cnt=1", prog_ptr, instr_count); end
    step();
    n_tests++; if (fault !== 1'b1 || running !== 1'b0 || prog_ptr !== 12'h3FF || instr_count !== 16'd1) begin n_fail++; $display("FAIL oob_inc got flt=%b run=%b ptr=%h cnt=%0d exp flt=1 run=0 ptr=3ff cnt=1", fault, running, prog_ptr, instr_count); end
    step();
    n_tests++; if (fault !== 1'b1 || prog_ptr !== 12'h3FF) begin n_fail++; $display("FAIL fault_hold got flt=%b ptr=%h exp flt=1 ptr=3ff", fault, prog_ptr); end
    do_start(12'h002);
    n_tests++; if (fault !== 1'b0 || running !== 1'b1 || prog_ptr !== 12'h002) begin n_fail++; $display("FAIL fault_recover got flt=%b run=%b ptr=%h exp flt=0 run=1 ptr=002", fault, running, prog_ptr); end
    branch_en = 1'b1; target = 12'hFF8;
    step();
    branch_en = 1'b0;
    n_tests++; if (fault !== 1'b1 || prog_ptr !== 12'h002 || instr_count !== 16'd0) begin n_fail++; $display("FAIL oob_wrap got flt=%b ptr=%h cnt=%0d exp flt=1 ptr=002 cnt=0", fault, prog_ptr, instr_count); end
    do_start(12'h100);
    n_tests++; if (fault !== 1'b0 || prog_ptr !== 12'h100) begin n_fail++; $display("FAIL fault_recover2 got flt=%b ptr=%h exp flt=0 ptr=100", fault, prog_ptr); end
  endtask

  task automatic test_restart_and_self_loop();
    branch_en = 1'b1; target = 12'h000;
    step();
    n_tests++; if (prog_ptr !== 12'h100 || instr_count !== 16'd1) begin n_fail++; $display("FAIL self_loop got ptr=%h cnt=%0d exp ptr=100 cnt=1", prog_ptr, instr_count); end
    Start = 1'b1; start_addr = 12'h200; halt = 1'b1; stall = 1'b1; target = 12'h010;
    step();
    Start = 1'b0; halt = 1'b0; stall = 1'b0; branch_en = 1'b0;
    n_tests++; if (prog_ptr !== 12'h200 || running !== 1'b1 || Done !== 1'b0 || instr_count !== 16'd0) begin n_fail++; $display("FAIL restart_in_run got ptr=%h run=%b done=%b cnt=%0d exp ptr=200 run=1 done=0 cnt=0", prog_ptr, running, Done, instr_count); end
  endtask

  task automatic test_async_reset();
    do_start(12'h120);
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (prog_ptr !== 12'h123 || instr_count !== 16'd3) begin n_fail++; $display("FAIL pre_reset got ptr=%h cnt=%0d exp ptr=123 cnt=3", prog_ptr, instr_count); end
    #2 Reset = 1'b0;
    #1;
    n_tests++; if (prog_ptr !== 12'h000 || running !== 1'b0 || Done !== 1'b0 || fault !== 1'b0 || instr_count !== 16'd0) begin n_fail++; $display("FAIL async_reset got ptr=%h run=%b done=%b flt=%b cnt=%0d exp all zero", prog_ptr, running, Done, fault, instr_count); end
    Reset = 1'b1;
    step();
    n_tests++; if (running !== 1'b0 || Done !== 1'b0 || prog_ptr !== 12'h000) begin n_fail++; $display("FAIL post_reset_idle got run=%b done=%b ptr=%h exp run=0 done=0 ptr=000", running, Done, prog_ptr); end
  endtask

  task automatic test_saturation();
    do_start(12'h000);
    for (int i = 0; i < 14; i++) step();
    n_tests++; if (s_count !== 4'hE) begin n_fail++; $display("FAIL sat_pre got %h exp e", s_count); end
    step();
    n_tests++; if (s_count !== 4'hF) begin n_fail++; $display("FAIL sat_max got %h exp f", s_count); end
    step();
    step();
    n_tests++; if (s_count !== 4'hF || s_prog_ptr !== 12'h011) begin n_fail++; $display("FAIL sat_hold got cnt=%h ptr=%h exp cnt=f ptr=011", s_count, s_prog_ptr); end
    n_tests++; if (instr_count !== 16'd17) begin n_fail++; $display("FAIL wide_count got %0d exp 17", instr_count); end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; start_addr = '0; branch_en = 1'b0;
    target = '0; stall = 1'b0; halt = 1'b0;
    test_reset();
    test_start_increment();
    test_branch();
    test_stall();
    test_halt();
    test_fault();
    test_restart_and_self_loop();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
